id_decode_stage: RTL



---
 rtl/id_pkg.sv | 82 ++++++++
 rtl/id_decode_comb.sv | 168 ++++++++++++++++
 rtl/id_decode_stage.sv | 136 +++++++++++++
 3 files changed

// File: rtl/id_pkg.sv
// Shared definitions for the RV32I decode stage: opcodes, immediate kinds,
// ALU operation codes, skid-buffer states and the decoded instruction bundle.
package id_pkg;

    localparam int ID_ALU_OP_W = 5;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_type_e;

    typedef enum logic [ID_ALU_OP_W-1:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_PASS_B = 5'd10,
        ALU_EQ     = 5'd11,
        ALU_NE     = 5'd12,
        ALU_LT     = 5'd13,
        ALU_GE     = 5'd14,
        ALU_LTU    = 5'd15,
        ALU_GEU    = 5'd16,
        ALU_MUL    = 5'd17,
        ALU_MULH   = 5'd18,
        ALU_MULHSU = 5'd19,
        ALU_MULHU  = 5'd20,
        ALU_DIV    = 5'd21,
        ALU_DIVU   = 5'd22,
        ALU_REM    = 5'd23,
        ALU_REMU   = 5'd24
    } alu_op_e;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        imm_type_e   imm_type;
        logic [2:0]  funct3;
        alu_op_e     alu_op;
        logic        alu_src_imm;
        logic        alu_src_pc;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        illegal;
    } bundle_t;

endpackage

// File: rtl/id_decode_comb.sv
// Pure combinational RV32I decoder: instruction word -> decoded bundle with a
// 32-bit sign-extended immediate. Define ID_RV32M_EN to accept the M extension.
module id_decode_comb
    import id_pkg::*;
(
    input  logic [31:0] inst,
    output bundle_t     bundle
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       illegal;
    bundle_t    d;

    assign opcode = inst[6:0];
    assign f3     = inst[14:12];
    assign f7     = inst[31:25];

    // Field extraction, control decode, immediate build; illegal encodings collapse to a bare flag.
    always_comb begin
        d          = '0;
        illegal    = 1'b0;
        d.rs1      = inst[19:15];
        d.rs2      = inst[24:20];
        d.rd       = inst[11:7];
        d.funct3   = f3;
        d.alu_op   = ALU_ADD;
        d.imm_type = IMM_I;
        case (opcode)
            OPC_LUI: begin
                d.imm_type    = IMM_U;
                d.alu_op      = ALU_PASS_B;
                d.alu_src_imm = 1'b1;
                d.reg_write   = 1'b1;
            end
            OPC_AUIPC: begin
                d.imm_type    = IMM_U;
                d.alu_src_imm = 1'b1;
                d.alu_src_pc  = 1'b1;
                d.reg_write   = 1'b1;
            end
            OPC_JAL: begin
                d.imm_type    = IMM_J;
                d.alu_src_imm = 1'b1;
                d.alu_src_pc  = 1'b1;
                d.reg_write   = 1'b1;
                d.jump        = 1'b1;
            end
            OPC_JALR: begin
                illegal       = (f3 != 3'b000);
                d.alu_src_imm = 1'b1;
                d.alu_src_pc  = 1'b1;
                d.reg_write   = 1'b1;
                d.jump        = 1'b1;
            end
            OPC_BRANCH: begin
                d.imm_type = IMM_B;
                d.branch   = 1'b1;
                case (f3)
                    3'b000:  d.alu_op = ALU_EQ;
                    3'b001:  d.alu_op = ALU_NE;
                    3'b100:  d.alu_op = ALU_LT;
                    3'b101:  d.alu_op = ALU_GE;
                    3'b110:  d.alu_op = ALU_LTU;
                    3'b111:  d.alu_op = ALU_GEU;
                    default: illegal  = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                illegal       = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
                d.alu_src_imm = 1'b1;
                d.mem_read    = 1'b1;
                d.reg_write   = 1'b1;
            end
            OPC_STORE: begin
                illegal       = (f3 > 3'b010);
                d.imm_type    = IMM_S;
                d.alu_src_imm = 1'b1;
                d.mem_write   = 1'b1;
            end
            OPC_OP_IMM: begin
                d.alu_src_imm = 1'b1;
                d.reg_write   = 1'b1;
                case (f3)
                    3'b000: d.alu_op = ALU_ADD;
                    3'b010: d.alu_op = ALU_SLT;
                    3'b011: d.alu_op = ALU_SLTU;
                    3'b100: d.alu_op = ALU_XOR;
                    3'b110: d.alu_op = ALU_OR;
                    3'b111: d.alu_op = ALU_AND;
                    3'b001: begin
                        d.alu_op = ALU_SLL;
                        illegal  = (f7 != 7'b0000000);
                    end
                    default: begin
                        if (f7 == 7'b0000000)      d.alu_op = ALU_SRL;
                        else if (f7 == 7'b0100000) d.alu_op = ALU_SRA;
                        else                       illegal  = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                d.reg_write = 1'b1;
                case (f7)
                    7'b0000000: begin
                        case (f3)
                            3'b000:  d.alu_op = ALU_ADD;
                            3'b001:  d.alu_op = ALU_SLL;
                            3'b010:  d.alu_op = ALU_SLT;
                            3'b011:  d.alu_op = ALU_SLTU;
                            3'b100:  d.alu_op = ALU_XOR;
                            3'b101:  d.alu_op = ALU_SRL;
                            3'b110:  d.alu_op = ALU_OR;
                            default: d.alu_op = ALU_AND;
                        endcase
                    end
                    7'b0100000: begin
                        if (f3 == 3'b000)      d.alu_op = ALU_SUB;
                        else if (f3 == 3'b101) d.alu_op = ALU_SRA;
                        else                   illegal  = 1'b1;
                    end
`ifdef ID_RV32M_EN
                    7'b0000001: begin
                        case (f3)
                            3'b000:  d.alu_op = ALU_MUL;
                            3'b001:  d.alu_op = ALU_MULH;
                            3'b010:  d.alu_op = ALU_MULHSU;
                            3'b011:  d.alu_op = ALU_MULHU;
                            3'b100:  d.alu_op = ALU_DIV;
                            3'b101:  d.alu_op = ALU_DIVU;
                            3'b110:  d.alu_op = ALU_REM;
                            default: d.alu_op = ALU_REMU;
                        endcase
                    end
`else
                    7'b0000001: illegal = 1'b1;
`endif
                    default: illegal = 1'b1;
                endcase
            end
            OPC_MISC_MEM: illegal = (f3 != 3'b000);
            OPC_SYSTEM:   illegal = (inst != INST_ECALL) && (inst != INST_EBREAK);
            default:      illegal = 1'b1;
        endcase
        if (inst[1:0] != 2'b11) begin
            illegal = 1'b1;
        end
        if (!d.reg_write) begin
            d.rd = 5'd0;
        end
        case (d.imm_type)
            IMM_I:   d.imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   d.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   d.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   d.imm = {inst[31:12], 12'b0};
            IMM_J:   d.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: d.imm = 32'd0;
        endcase
        if (illegal) begin
            d         = '0;
            d.illegal = 1'b1;
        end
    end

    assign bundle = d;

endmodule

// File: rtl/id_decode_stage.sv
// Registered RV32I decode stage with a two-entry skid buffer between fetch and
// execute. M-extension decode is enabled by defining ID_RV32M_EN.
module id_decode_stage
    import id_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_inst,
    input  logic [XLEN-1:0]     in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [4:0]          out_rs1_addr,
    output logic [4:0]          out_rs2_addr,
    output logic [4:0]          out_rd_addr,
    output logic [XLEN-1:0]     out_imm,
    output logic [2:0]          out_imm_type,
    output logic [2:0]          out_funct3,
    output logic [ALU_OP_W-1:0] out_alu_op,
    output logic                out_alu_src_imm,
    output logic                out_alu_src_pc,
    output logic                out_reg_write,
    output logic                out_mem_read,
    output logic                out_mem_write,
    output logic                out_branch,
    output logic                out_jump,
    output logic                out_illegal
);

    bundle_t          dec_bundle;
    buf_state_e       state_q, state_d;
    bundle_t          main_q, main_d, skid_q, skid_d;
    logic [XLEN-1:0]  main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             accept;
    logic signed [31:0] imm_s;

    id_decode_comb u_decode (
        .inst   (in_inst),
        .bundle (dec_bundle)
    );

    assign accept = in_valid && in_ready_q && !flush;

    // Next-state for the skid buffer: main entry is what execute sees, skid catches one stalled accept.
    always_comb begin
        state_d   = state_q;
        main_d    = main_q;
        main_pc_d = main_pc_q;
        skid_d    = skid_q;
        skid_pc_d = skid_pc_q;
        case (state_q)
            BUF_EMPTY: begin
                if (accept) begin
                    main_d    = dec_bundle;
                    main_pc_d = in_pc;
                    state_d   = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (accept && out_ready) begin
                    main_d    = dec_bundle;
                    main_pc_d = in_pc;
                end else if (accept) begin
                    skid_d    = dec_bundle;
                    skid_pc_d = in_pc;
                    state_d   = BUF_FULL;
                end else if (out_ready) begin
                    state_d   = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (out_ready) begin
                    main_d    = skid_q;
                    main_pc_d = skid_pc_q;
                    state_d   = BUF_ONE;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
        if (flush) begin
            state_d = BUF_EMPTY;
        end
        in_ready_d  = (state_d != BUF_FULL);
        out_valid_d = (state_d != BUF_EMPTY);
    end

    // All stage state, with synchronous reset clearing the payload and handshake flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BUF_EMPTY;
            main_q      <= '0;
            main_pc_q   <= '0;
            skid_q      <= '0;
            skid_pc_q   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            main_pc_q   <= main_pc_d;
            skid_q      <= skid_d;
            skid_pc_q   <= skid_pc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign imm_s           = main_q.imm;
    assign in_ready        = in_ready_q;
    assign out_valid       = out_valid_q;
    assign out_pc          = main_pc_q;
    assign out_rs1_addr    = main_q.rs1;
    assign out_rs2_addr    = main_q.rs2;
    assign out_rd_addr     = main_q.rd;
    assign out_imm         = XLEN'(imm_s);
    assign out_imm_type    = main_q.imm_type;
    assign out_funct3      = main_q.funct3;
    assign out_alu_op      = ALU_OP_W'(main_q.alu_op);
    assign out_alu_src_imm = main_q.alu_src_imm;
    assign out_alu_src_pc  = main_q.alu_src_pc;
    assign out_reg_write   = main_q.reg_write;
    assign out_mem_read    = main_q.mem_read;
    assign out_mem_write   = main_q.mem_write;
    assign out_branch      = main_q.branch;
    assign out_jump        = main_q.jump;
    assign out_illegal     = main_q.illegal;

endmodule
